// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: in-order fetch requests to imem, responses queued for decode, redirect flushes.
// Response-to-out_* latency 1 cycle (no bypass); fetch stalls when queued + in-flight reaches DEPTH.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        i_req,
    output logic [31:0] i_addr,
    input  logic        i_gnt,
    input  logic        i_rvalid,
    input  logic [31:0] i_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ir,
    output logic [31:0] out_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] occ;
    logic [CW-1:0] outs;
    logic [CW-1:0] discard;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   ir_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];

    logic [CW:0]   inflight;
    logic          grant;
    logic          resp;
    logic          push;
    logic          drop;
    logic          pop;
    logic [CW-1:0] outs_nxt;
    logic [31:0]   redirect_aligned;
    logic          unused_bits;

    assign inflight         = {1'b0, occ} + {1'b0, outs};
    assign i_req            = (state == RUN) && (inflight < DEPTH_W) && !redirect;
    assign i_addr           = {fetch_pc[31:2], 2'b00};
    assign grant            = i_req && i_gnt;
    // Responses with nothing outstanding are protocol errors and are ignored.
    assign resp             = i_rvalid && (outs != '0);
    assign push             = resp && (discard == '0) && !redirect;
    assign drop             = resp && (discard != '0) && !redirect;
    assign pop              = out_valid && out_ready && !redirect;
    assign outs_nxt         = outs + CW'(grant) - CW'(resp);
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign unused_bits      = ^redirect_pc[1:0];

    assign out_valid = (occ != '0);
    assign out_ir    = out_valid ? ir_mem[rd_ptr] : 32'hEEEE_7777;
    assign out_pc    = out_valid ? pc_mem[rd_ptr] : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr] <= i_rdata;
            pc_mem[wr_ptr] <= {resp_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            resp_pc  <= {RESET_PC[31:2], 2'b00};
            occ      <= '0;
            outs     <= '0;
            discard  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            outs <= outs_nxt;
            if (redirect) begin
                // Every response still in flight belongs to the old path.
                occ      <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fetch_pc <= redirect_aligned;
                resp_pc  <= redirect_aligned;
                discard  <= outs_nxt;
                state    <= (outs_nxt != '0) ? DRAIN : RUN;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                occ <= occ + CW'(push) - CW'(pop);
                if (drop) begin
                    discard <= discard - CW'(1);
                end
                case (state)
                    IDLE:    state <= RUN;
                    RUN:     state <= RUN;
                    DRAIN:   if (discard == '0) state <= RUN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter: RESET_PC, 32'h00000000, first fetch address after reset.
REQ-003 SHALL have port: clk  input  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: i_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port: i_addr  output  32  fetch address, word aligned.
REQ-007 SHALL have port: i_gnt  input  1  request accepted this cycle (i_req & i_gnt).
REQ-008 SHALL have port: i_rvalid  input  1  read data returned, in request order.
REQ-009 SHALL have port: i_rdata  input  32  returned instruction word.
REQ-010 SHALL have port: redirect  input  1  branch/jump taken; flush and refetch.
REQ-011 SHALL have port: redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-012 SHALL have port: out_valid  output  1  out_ir/out_pc hold a valid instruction.
REQ-013 SHALL have port: out_ready  input  1  decode consumes head entry when out_valid & out_ready.
REQ-014 SHALL have port: out_ir  output  32  head instruction word.
REQ-015 SHALL have port: out_pc  output  32  address of head instruction.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN; IDLE lasts exactly one cycle after reset, then RUN.
REQ-017 SHALL track fetch_pc, occupancy (0..DEPTH), outstanding (granted, not returned) and discard count.
REQ-018 SHALL assert i_req in RUN only when occupancy + outstanding < DEPTH; never in IDLE or DRAIN.
REQ-019 SHALL drive i_addr = {fetch_pc[31:2],2'b00} and hold i_req/i_addr stable until i_gnt, except on redirect.
REQ-020 SHALL advance fetch_pc by 4 on each grant, wrapping 32'hFFFFFFFC -> 32'h00000000.
REQ-021 SHALL enqueue {fetch address, i_rdata} on i_rvalid when discard count is 0; data visible on out_* the following cycle (no bypass).
REQ-022 SHALL pop head on out_valid & out_ready; simultaneous push and pop leave occupancy unchanged, including when full.
REQ-023 SHALL hold out_ir = 32'hEEEE7777 and out_pc = 0 while out_valid is 0.
REQ-024 SHALL on redirect: empty queue, set fetch_pc = {redirect_pc[31:2],2'b00}, discard count = outstanding (including a grant in the same cycle), withdraw i_req that cycle.
REQ-025 SHALL enter DRAIN after redirect if discard count > 0, else RUN; DRAIN returns to RUN the cycle after discard count reaches 0.
REQ-026 SHALL in DRAIN drop each i_rvalid response and decrement discard count; dropped data never reaches out_*.
REQ-027 SHALL give redirect priority over same-cycle i_rvalid (dropped), out_ready pop (ignored), and any queued entries.
REQ-028 SHALL accept redirect in any state; a redirect during DRAIN replaces fetch_pc and keeps counting outstanding responses.
REQ-029 SHALL ignore i_rvalid when outstanding is 0 (protocol error, no state change).

Reset
REQ-030 SHALL on reset: out_valid 0, out_ir 32'hEEEE7777, out_pc 0, i_req 0, fetch_pc RESET_PC, occupancy/outstanding/discard 0, state IDLE.
REQ-031 SHALL abandon in-flight requests on reset mid-operation; responses arriving during or after reset with outstanding 0 are ignored per REQ-029.
REQ-032 SHALL issue first i_req with i_addr = RESET_PC on the second cycle after reset deasserts.

Verification
REQ-033 SHALL verify streaming: i_gnt=1, 1-cycle i_rvalid, out_ready=1 -> out_pc 0,4,8,... one per cycle, matching i_rdata.
REQ-034 SHALL verify backpressure: out_ready=0, DEPTH=4 -> exactly 4 grants, then i_req low; out_ready=1 resumes fetch at 0x10.
REQ-035 SHALL verify redirect with 2 outstanding to 0x203 -> next i_addr 0x200 after both stale responses dropped, out_pc first 0x200.
REQ-036 SHALL verify redirect same cycle as i_rvalid and out_ready -> response dropped, out_valid 0 next cycle.
REQ-037 SHALL verify wrap: redirect_pc 0xFFFFFFF8 -> out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-038 SHALL verify reset mid-stream with 3 queued entries -> out_valid 0, out_ir 0xEEEE7777 next cycle, refetch from RESET_PC.
